// File: rtl/filter_rule_sched.sv
// filter_rule_sched: first-match rule-table lookup controller.
// It latches a parsed header on hdr_rd. It then scans NUM_RULES rules, one per
// cycle, with the lowest index winning. It registers a send decision for the
// output FIFO and holds it until the parser pulses hdr_clear.
// Ports:
//   axi_aclk / axi_aresetn          clock, async active-low reset
//   hdr_rd, hdr_clear, hdr_*        parser handshake and header fields
//   cfg_*                           one-cycle rule write port
//   m_send, m_send_rd               decision and decision-valid
//   match_hit, match_idx            decision source
//   busy, hit_cnt, drop_cnt         status and statistics
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no packet in flight; waits for hdr_rd
// SCAN       | evaluates rule[idx_q] on the latched header, one per cycle
// WAIT_CLEAR | decision registered and held until hdr_clear
module filter_rule_sched #(
  parameter int NUM_RULES      = 8,
  parameter int IP_ADDR_LEN    = 32,
  parameter int PORT_LEN       = 16,
  parameter bit DEFAULT_ACTION = 1'b0,
  localparam int IDX_W         = $clog2(NUM_RULES)
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic                   hdr_rd,
  input  logic                   hdr_clear,
  input  logic [IP_ADDR_LEN-1:0] hdr_src_ip,
  input  logic [IP_ADDR_LEN-1:0] hdr_dst_ip,
  input  logic [PORT_LEN-1:0]    hdr_dst_port,
  input  logic                   cfg_wr,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic                   cfg_valid,
  input  logic                   cfg_action,
  input  logic [IP_ADDR_LEN-1:0] cfg_src_ip,
  input  logic [IP_ADDR_LEN-1:0] cfg_src_mask,
  input  logic [IP_ADDR_LEN-1:0] cfg_dst_ip,
  input  logic [IP_ADDR_LEN-1:0] cfg_dst_mask,
  input  logic [PORT_LEN-1:0]    cfg_dst_port,
  output logic                   m_send,
  output logic                   m_send_rd,
  output logic                   match_hit,
  output logic [IDX_W-1:0]       match_idx,
  output logic                   busy,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            drop_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, WAIT_CLEAR} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  // Rule table; only the valid bits need a reset value
  logic                   valid_q    [NUM_RULES];
  logic                   action_q   [NUM_RULES];
  logic [IP_ADDR_LEN-1:0] src_ip_q   [NUM_RULES];
  logic [IP_ADDR_LEN-1:0] src_mask_q [NUM_RULES];
  logic [IP_ADDR_LEN-1:0] dst_ip_q   [NUM_RULES];
  logic [IP_ADDR_LEN-1:0] dst_mask_q [NUM_RULES];
  logic [PORT_LEN-1:0]    dst_port_q [NUM_RULES];

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IP_ADDR_LEN-1:0] hdr_src_q;
  logic [IP_ADDR_LEN-1:0] hdr_dst_q;
  logic [PORT_LEN-1:0]    hdr_port_q;
  logic                   rule_match;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_RULES; i++) valid_q[i] <= 1'b0;
    end else if (cfg_wr) begin
      valid_q[cfg_idx] <= cfg_valid;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (cfg_wr) begin
      action_q[cfg_idx]   <= cfg_action;
      src_ip_q[cfg_idx]   <= cfg_src_ip;
      src_mask_q[cfg_idx] <= cfg_src_mask;
      dst_ip_q[cfg_idx]   <= cfg_dst_ip;
      dst_mask_q[cfg_idx] <= cfg_dst_mask;
      dst_port_q[cfg_idx] <= cfg_dst_port;
    end
  end

  // The compare reads the table as it stands before this edge. A same-cycle
  // write to rule[idx_q] therefore only takes effect for later packets.
  assign rule_match = valid_q[idx_q]
    && (((hdr_src_q ^ src_ip_q[idx_q]) & src_mask_q[idx_q]) == '0)
    && (((hdr_dst_q ^ dst_ip_q[idx_q]) & dst_mask_q[idx_q]) == '0)
    && ((dst_port_q[idx_q] == '0) || (dst_port_q[idx_q] == hdr_port_q));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hdr_src_q  <= '0;
      hdr_dst_q  <= '0;
      hdr_port_q <= '0;
      m_send     <= 1'b0;
      m_send_rd  <= 1'b0;
      match_hit  <= 1'b0;
      match_idx  <= '0;
      busy       <= 1'b0;
      hit_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          m_send    <= 1'b0;
          m_send_rd <= 1'b0;
          if (hdr_rd) begin
            hdr_src_q  <= hdr_src_ip;
            hdr_dst_q  <= hdr_dst_ip;
            hdr_port_q <= hdr_dst_port;
            idx_q      <= '0;
            busy       <= 1'b1;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (rule_match) begin
            m_send    <= action_q[idx_q];
            match_hit <= 1'b1;
            match_idx <= idx_q;
            m_send_rd <= 1'b1;
            hit_cnt   <= hit_cnt + 32'd1;
            if (!action_q[idx_q]) drop_cnt <= drop_cnt + 32'd1;
            state_q   <= WAIT_CLEAR;
          end else if (idx_q == LAST_IDX) begin
            m_send    <= DEFAULT_ACTION;
            match_hit <= 1'b0;
            match_idx <= '0;
            m_send_rd <= 1'b1;
            if (!DEFAULT_ACTION) drop_cnt <= drop_cnt + 32'd1;
            state_q   <= WAIT_CLEAR;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        WAIT_CLEAR: begin
          if (hdr_clear) begin
            m_send    <= 1'b0;
            m_send_rd <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_rule_sched.sv
module tb_filter_rule_sched;

  localparam int NR = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hdr_rd, hdr_clear;
  logic [31:0]   hdr_src_ip, hdr_dst_ip;
  logic [15:0]   hdr_dst_port;
  logic          cfg_wr, cfg_valid, cfg_action;
  logic [IW-1:0] cfg_idx;
  logic [31:0]   cfg_src_ip, cfg_src_mask, cfg_dst_ip, cfg_dst_mask;
  logic [15:0]   cfg_dst_port;
  logic          m_send, m_send_rd, match_hit, busy;
  logic [IW-1:0] match_idx;
  logic [31:0]   hit_cnt, drop_cnt;

  filter_rule_sched #(.NUM_RULES(NR), .IP_ADDR_LEN(32), .PORT_LEN(16), .DEFAULT_ACTION(1'b0)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .hdr_rd(hdr_rd), .hdr_clear(hdr_clear),
    .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip), .hdr_dst_port(hdr_dst_port),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_action(cfg_action),
    .cfg_src_ip(cfg_src_ip), .cfg_src_mask(cfg_src_mask),
    .cfg_dst_ip(cfg_dst_ip), .cfg_dst_mask(cfg_dst_mask), .cfg_dst_port(cfg_dst_port),
    .m_send(m_send), .m_send_rd(m_send_rd), .match_hit(match_hit), .match_idx(match_idx),
    .busy(busy), .hit_cnt(hit_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          send;
    logic          hit;
    logic [IW-1:0] idx;
    int            lat;
    logic [31:0]   hits;
    logic [31:0]   drops;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;

  // Reference rule table
  logic        r_valid [NR];
  logic        r_act   [NR];
  logic [31:0] r_src [NR], r_smask [NR], r_dst [NR], r_dmask [NR];
  logic [15:0] r_port [NR];
  logic [31:0] m_hits, m_drops;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic write_rule(input int i, input logic v, input logic a,
                            input logic [31:0] s, input logic [31:0] sm,
                            input logic [31:0] d, input logic [31:0] dm,
                            input logic [15:0] p);
    cfg_wr = 1'b1; cfg_idx = IW'(i); cfg_valid = v; cfg_action = a;
    cfg_src_ip = s; cfg_src_mask = sm; cfg_dst_ip = d; cfg_dst_mask = dm; cfg_dst_port = p;
    @(negedge clk);
    cfg_wr = 1'b0;
    r_valid[i] = v; r_act[i] = a; r_src[i] = s; r_smask[i] = sm;
    r_dst[i] = d; r_dmask[i] = dm; r_port[i] = p;
  endtask

  // Pulses hdr_rd across one edge and pushes the reference decision
  task automatic start_hdr(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p);
    exp_t e;
    bit found = 0;
    e.send = 1'b0; e.hit = 1'b0; e.idx = '0; e.lat = NR;
    for (int i = 0; i < NR; i++) begin
      if (!found && r_valid[i] && ((s & r_smask[i]) == (r_src[i] & r_smask[i]))
          && ((d & r_dmask[i]) == (r_dst[i] & r_dmask[i]))
          && (r_port[i] == 16'd0 || r_port[i] == p)) begin
        found = 1; e.send = r_act[i]; e.hit = 1'b1; e.idx = IW'(i); e.lat = i + 1;
      end
    end
    if (e.hit) m_hits = m_hits + 1;
    if (!e.send) m_drops = m_drops + 1;
    e.hits = m_hits; e.drops = m_drops;
    exp_q.push_back(e);
    hdr_src_ip = s; hdr_dst_ip = d; hdr_dst_port = p; hdr_rd = 1'b1;
    @(negedge clk);
    hdr_rd = 1'b0;
    // scramble fields: the lookup must use the latched copy
    hdr_src_ip = ~s; hdr_dst_ip = ~d; hdr_dst_port = ~p;
  endtask

  task automatic wait_decision(input string name);
    int lat = 0;
    while (!m_send_rd && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    last_e = exp_q.pop_front();
    tests_run++;
    if (!m_send_rd) begin
      tests_failed++;
      $display("FAIL %s timeout: m_send_rd never rose", name);
      return;
    end
    tests_run++;
    if (lat !== last_e.lat || m_send !== last_e.send || match_hit !== last_e.hit
        || match_idx !== last_e.idx) begin
      tests_failed++;
      $display("FAIL %s decision: got lat=%0d send=%0b hit=%0b idx=%0d, want lat=%0d send=%0b hit=%0b idx=%0d",
               name, lat, m_send, match_hit, match_idx, last_e.lat, last_e.send, last_e.hit, last_e.idx);
    end
    tests_run++;
    if (hit_cnt !== last_e.hits || drop_cnt !== last_e.drops || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s counters: got hit=%0d drop=%0d busy=%0b, want hit=%0d drop=%0d busy=1",
               name, hit_cnt, drop_cnt, busy, last_e.hits, last_e.drops);
    end
  endtask

  task automatic clear_hdr(input string name);
    hdr_clear = 1'b1;
    @(negedge clk);
    hdr_clear = 1'b0;
    tests_run++;
    if (m_send_rd !== 1'b0 || m_send !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s clear: got rd=%0b send=%0b busy=%0b, want 0 0 0", name, m_send_rd, m_send, busy);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if (m_send !== 1'b0 || m_send_rd !== 1'b0 || match_hit !== 1'b0 || match_idx !== '0
        || busy !== 1'b0 || hit_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL %s reset outputs: send=%0b rd=%0b hit=%0b idx=%0d busy=%0b hits=%0d drops=%0d, want all 0",
               name, m_send, m_send_rd, match_hit, match_idx, busy, hit_cnt, drop_cnt);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) r_valid[i] = 1'b0;
    m_hits = 0; m_drops = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hdr_rd = 0; hdr_clear = 0; cfg_wr = 0; cfg_idx = '0; cfg_valid = 0; cfg_action = 0;
    hdr_src_ip = 0; hdr_dst_ip = 0; hdr_dst_port = 0;
    cfg_src_ip = 0; cfg_src_mask = 0; cfg_dst_ip = 0; cfg_dst_mask = 0; cfg_dst_port = 0;
    for (int i = 0; i < NR; i++) begin
      r_act[i] = 0; r_src[i] = 0; r_smask[i] = 0; r_dst[i] = 0; r_dmask[i] = 0; r_port[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss();
    start_hdr(32'h0A000001, 32'h01020304, 16'd80);
    wait_decision("miss");
    clear_hdr("miss");
  endtask

  task automatic test_hit();
    write_rule(3, 1, 1, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, 32'h0, 16'd0);
    start_hdr(32'hAAAAAAAA, 32'h12345678, 16'd1234);
    wait_decision("hit");
    clear_hdr("hit");
  endtask

  task automatic test_priority();
    write_rule(1, 1, 0, 32'h0A000000, 32'hFF000000, 32'h0, 32'h0, 16'd0);
    write_rule(5, 1, 1, 32'h0A000001, 32'hFFFFFFFF, 32'h0, 32'h0, 16'd0);
    start_hdr(32'h0A000001, 32'h0, 16'd53);
    wait_decision("priority");
    clear_hdr("priority");
  endtask

  task automatic test_port();
    write_rule(0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd80);
    start_hdr(32'h0B000000, 32'hC0A80001, 16'd80);
    wait_decision("port_80");
    clear_hdr("port_80");
    start_hdr(32'h0B000000, 32'hC0A80001, 16'd443);
    wait_decision("port_443");
    clear_hdr("port_443");
    write_rule(0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    start_hdr(32'h0B000000, 32'hC0A80001, 16'd443);
    wait_decision("port_wild");
    clear_hdr("port_wild");
  endtask

  task automatic test_handshake();
    int bad = 0;
    logic [31:0] h0;
    start_hdr(32'h0B000000, 32'h0, 16'd22);
    wait_decision("hs_first");
    h0 = hit_cnt;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin
        hdr_src_ip = 32'h0A000001; hdr_rd = 1'b1;
      end else begin
        hdr_rd = 1'b0;
      end
      @(negedge clk);
      if (m_send_rd !== 1'b1 || m_send !== last_e.send || match_hit !== last_e.hit
          || match_idx !== last_e.idx || hit_cnt !== h0) bad++;
    end
    hdr_rd = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL hs_hold: %0d unstable cycles, want 0", bad);
    end
    // hdr_clear at edge c, new hdr_rd accepted at edge c+1
    hdr_clear = 1'b1;
    @(negedge clk);
    hdr_clear = 1'b0;
    tests_run++;
    if (m_send_rd !== 1'b0 || m_send !== 1'b0) begin
      tests_failed++;
      $display("FAIL hs_release: got rd=%0b send=%0b, want 0 0", m_send_rd, m_send);
    end
    start_hdr(32'hAAAAAAAA, 32'h0, 16'd7);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hs_turnaround: busy=%0b, want 1", busy);
    end
    wait_decision("hs_second");
    clear_hdr("hs_second");
  endtask

  task automatic test_back_to_back();
    logic [31:0] srcs [4];
    srcs[0] = 32'hAAAAAAAA; srcs[1] = 32'h0A000001; srcs[2] = 32'h0A00FFFF; srcs[3] = 32'h55555555;
    write_rule(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    write_rule(6, 1, 1, 32'h0, 32'h0, 32'hC0A80000, 32'hFFFF0000, 16'd443);
    for (int n = 0; n < 8; n++) begin
      start_hdr(srcs[$urandom_range(0, 3)], ($urandom_range(0, 1) != 0) ? 32'hC0A80101 : 32'h08080808,
                ($urandom_range(0, 1) != 0) ? 16'd443 : 16'd80);
      wait_decision("b2b");
      clear_hdr("b2b");
    end
  endtask

  task automatic test_reset_mid();
    // rule 6 matches this header, so no decision can precede the reset
    write_rule(3, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    write_rule(5, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    write_rule(1, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    start_hdr(32'h01010101, 32'hC0A80505, 16'd443);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_hdr(32'h01010101, 32'hC0A80505, 16'd443);
    wait_decision("after_reset");
    clear_hdr("after_reset");
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_priority();
    test_port();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
